// File: rtl/binary_tx_if.sv
// Word-in / serial-out handshake bundle for binary_tx.
// The master side offers words and observes the stream; binary_tx is the slave.
interface binary_tx_if;
  logic       valid;
  logic [7:0] data;
  logic [3:0] nbits;
  logic       abort;
  logic       ready;
  logic       w;
  logic       w_en;
  logic       done;
  logic [1:0] state;

  modport master (
    output valid,
    output data,
    output nbits,
    output abort,
    input  ready,
    input  w,
    input  w_en,
    input  done,
    input  state
  );

  modport slave (
    input  valid,
    input  data,
    input  nbits,
    input  abort,
    output ready,
    output w,
    output w_en,
    output done,
    output state
  );
endinterface

// File: rtl/binary_tx.sv
// binary_tx: serializes a 1..8 bit word MSB first onto w, qualified by w_en.
// Each word is followed by a one-cycle GAP that pulses done.
// All outputs decode registered state only.
module binary_tx (
  input  logic        clk,
  input  logic        rst_n,
  binary_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StSend    = 2'b01,
    StGap     = 2'b10,
    StIllegal = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] eff_nbits;

  // 0 and 9..15 mean a full byte.
  assign eff_nbits = ((bus.nbits == 4'd0) || (bus.nbits > 4'd8)) ? 4'd8 : bus.nbits;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        // abort is ignored here, so a word offered alongside it is still taken
        if (bus.valid) begin
          sr_d    = bus.data;
          cnt_d   = eff_nbits;
          state_d = StSend;
        end
      end
      StSend: begin
        if (bus.abort) begin
          // abort wins even on the last-bit edge: no GAP, no done
          sr_d    = 8'h00;
          cnt_d   = 4'd0;
          state_d = StIdle;
        end else begin
          sr_d  = {sr_q[6:0], 1'b0};
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        sr_d    = 8'h00;
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
      default: begin
        sr_d    = 8'h00;
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  // State, shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= 8'h00;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    bus.ready = (state_q == StIdle);
    bus.w_en  = (state_q == StSend);
    bus.w     = (state_q == StSend) & sr_q[7];
    bus.done  = (state_q == StGap);
    bus.state = state_q;
  end

endmodule

// File: tb/tb_binary_tx.sv
// Directed self-checking bench for binary_tx.
module tb_binary_tx;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  binary_tx_if bus ();

  binary_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: actual=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: actual=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk2({tag, "_state"}, bus.state, 2'b00);
    chk1({tag, "_ready"}, bus.ready, 1'b1);
    chk1({tag, "_w"}, bus.w, 1'b0);
    chk1({tag, "_w_en"}, bus.w_en, 1'b0);
    chk1({tag, "_done"}, bus.done, 1'b0);
  endtask

  // Offer one word at a negedge in IDLE and check n SEND cycles, GAP and IDLE.
  // expbits holds the hand-computed stream, first bit in expbits[7].
  // With pulse_valid, valid is re-raised with data=0 mid-word.
  task automatic send_word(input string tag, input logic [7:0] d, input logic [3:0] nb,
                           input logic [7:0] expbits, input int n, input bit pulse_valid);
    logic [7:0] e;
    e = expbits;
    @(negedge clk);
    chk1({tag, "_ready_pre"}, bus.ready, 1'b1);
    bus.valid = 1'b1;
    bus.data  = d;
    bus.nbits = nb;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.valid = 1'b0;
        bus.data  = ~d;
        bus.nbits = 4'd1;
      end
      if (pulse_valid && i == 2) begin
        bus.valid = 1'b1;
        bus.data  = 8'h00;
      end
      if (pulse_valid && i == 3) bus.valid = 1'b0;
      chk2({tag, "_send_state"}, bus.state, 2'b01);
      chk1({tag, "_send_w_en"}, bus.w_en, 1'b1);
      chk1({tag, "_send_ready"}, bus.ready, 1'b0);
      chk1({tag, "_send_w"}, bus.w, e[7]);
      e = {e[6:0], 1'b0};
    end
    @(negedge clk);
    chk2({tag, "_gap_state"}, bus.state, 2'b10);
    chk1({tag, "_gap_done"}, bus.done, 1'b1);
    chk1({tag, "_gap_w"}, bus.w, 1'b0);
    chk1({tag, "_gap_w_en"}, bus.w_en, 1'b0);
    chk1({tag, "_gap_ready"}, bus.ready, 1'b0);
    @(negedge clk);
    chk_idle({tag, "_after"});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.valid = 1'b0;
    bus.data  = 8'h00;
    bus.nbits = 4'd0;
    bus.abort = 1'b0;

    // Reset values before any clock edge.
    #2;
    chk_idle("reset");
    #1 rst_n = 1'b1;
    #1;
    chk_idle("release");

    // Full byte A5.
    send_word("a5", 8'hA5, 4'd8, 8'b1010_0101, 8, 1'b0);
    // Three bits of C0.
    send_word("c0n3", 8'hC0, 4'd3, 8'b1100_0000, 3, 1'b0);
    // nbits=0 and nbits=12 both mean 8.
    send_word("ffn0", 8'hFF, 4'd0, 8'b1111_1111, 8, 1'b0);
    send_word("5an12", 8'h5A, 4'd12, 8'b0101_1010, 8, 1'b0);
    // Single bit, and nbits above 1 only taking the top bits of A5.
    send_word("80n1", 8'h80, 4'd1, 8'b1000_0000, 1, 1'b0);
    send_word("a5n5", 8'hA5, 4'd5, 8'b1010_0000, 5, 1'b0);
    // valid pulsed with new data mid-word must not disturb the stream.
    send_word("mid_valid", 8'h96, 4'd8, 8'b1001_0110, 8, 1'b1);

    // Abort at bit 4 of FF.
    @(negedge clk);
    bus.valid = 1'b1;
    bus.data  = 8'hFF;
    bus.nbits = 4'd8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.valid = 1'b0;
      chk1("abort4_w", bus.w, 1'b1);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk_idle("abort4_next");
    @(negedge clk);
    chk_idle("abort4_nodone");

    // Abort on the last-bit edge of a 3-bit word.
    @(negedge clk);
    bus.valid = 1'b1;
    bus.data  = 8'hE0;
    bus.nbits = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.valid = 1'b0;
      chk2("abortlast_state", bus.state, 2'b01);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk_idle("abortlast_next");
    @(negedge clk);
    chk_idle("abortlast_nodone");

    // abort together with valid in IDLE still accepts.
    @(negedge clk);
    bus.valid = 1'b1;
    bus.abort = 1'b1;
    bus.data  = 8'h80;
    bus.nbits = 4'd2;
    @(negedge clk);
    bus.valid = 1'b0;
    bus.abort = 1'b0;
    chk2("idle_abort_accept_state", bus.state, 2'b01);
    chk1("idle_abort_accept_w", bus.w, 1'b1);
    @(negedge clk);
    chk1("idle_abort_bit1", bus.w, 1'b0);
    @(negedge clk);
    chk1("idle_abort_done", bus.done, 1'b1);
    @(negedge clk);
    chk_idle("idle_abort_end");

    // Asynchronous reset at SEND bit 2, between clock edges.
    @(negedge clk);
    bus.valid = 1'b1;
    bus.data  = 8'hFF;
    bus.nbits = 4'd8;
    @(negedge clk);
    bus.valid = 1'b0;
    @(negedge clk);
    chk1("prerst_w_en", bus.w_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge clk);
    chk_idle("rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rst_after_nodone");
    send_word("81", 8'h81, 4'd8, 8'b1000_0001, 8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_tx.md
BINARY_TX -- requirements
Module: binary_tx

Interface
REQ-001 The block SHALL have exactly one clock and one reset; Reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous active-low reset; 0 forces reset state immediately.
REQ-004 valid  input  1  word offered on data/nbits.
REQ-005 data  input  8  word to serialize, MSB first.
REQ-006 nbits  input  4  bits to send; 1..8 used as given; 0 or 9..15 treated as 8.
REQ-007 abort  input  1  synchronous abort of the word in progress.
REQ-008 ready  output  1  block accepts a word this cycle.
REQ-009 w  output  1  serial bit stream, drives the w input of the detector.
REQ-010 w_en  output  1  w carries a valid payload bit this cycle.
REQ-011 done  output  1  one-cycle pulse after the last bit of a non-aborted word.
REQ-012 State  output  2  current state code: 00 IDLE, 01 SEND, 10 GAP.

Function
REQ-013 The block SHALL hold a 3-state binary-encoded FSM (IDLE, SEND, GAP), an 8-bit shift register and a 4-bit bit counter.
REQ-014 ready SHALL be 1 in IDLE only, decoded from State.
REQ-015 Acceptance SHALL occur on a rising edge with valid=1 and ready=1: shift register <= data, counter <= effective nbits, IDLE -> SEND.
REQ-016 data and nbits SHALL be sampled only at acceptance; later changes SHALL NOT affect the word in flight.
REQ-017 valid SHALL be ignored in SEND and GAP; no queuing.
REQ-018 In SEND, w SHALL equal shift register bit 7 and w_en SHALL be 1; each edge shifts left by one (LSB filled with 0) and decrements the counter.
REQ-019 SEND -> GAP SHALL occur on the edge where the counter equals 1, so a word occupies exactly N consecutive SEND cycles (N = effective nbits).
REQ-020 GAP SHALL last exactly one cycle: w=0, w_en=0, done=1, then GAP -> IDLE unconditionally.
REQ-021 Outside SEND, w and w_en SHALL be 0; done SHALL be 1 only in a GAP entered from normal completion.
REQ-022 abort=1 in SEND SHALL move SEND -> IDLE on that edge, clear the shift register and counter, and SHALL NOT produce done.
REQ-023 abort SHALL be ignored in IDLE and GAP; abort with valid in IDLE SHALL still accept.
REQ-024 abort on the same edge as the last bit (counter=1) SHALL take priority: -> IDLE, no done.
REQ-025 Minimum spacing between acceptances SHALL be N+2 cycles (N SEND + GAP + IDLE).
REQ-026 Illegal State code 11 SHALL transition to IDLE on the next edge with all outputs at reset values.
REQ-027 w, w_en, done and State SHALL be glitch-free functions of registered state only (no combinational path from inputs).

Reset
REQ-028 Reset=0 SHALL immediately force State=00, shift register=0, counter=0, w=0, w_en=0, done=0, ready=1, regardless of clk.
REQ-029 Reset=0 mid-word SHALL discard the word with no done; after release the first edge with valid=1 SHALL accept.

Verification
REQ-030 Reset low then released -> State=00, ready=1, w=0, w_en=0, done=0 before any clock edge.
REQ-031 valid=1, data=8'hA5, nbits=8 -> w=1,0,1,0,0,1,0,1 on 8 cycles with w_en=1; next cycle State=10, done=1; next State=00, ready=1.
REQ-032 data=8'hC0, nbits=3 -> w=1,1,0 over 3 SEND cycles, then done=1 for one cycle; nbits=0 with data=8'hFF -> 8 bits of 1.
REQ-033 During SEND change data to 8'h00 and pulse valid -> stream unchanged, no second word accepted until ready=1 again.
REQ-034 abort=1 at SEND bit 4 of 8'hFF -> State=00 next cycle, w=0, no done pulse; abort on the last-bit edge -> no done.
REQ-035 Reset=0 asynchronously at SEND bit 2 -> outputs at reset values within the same cycle; new word 8'h81 afterwards -> 1,0,0,0,0,0,0,1.
